rv_gpio: RTL

//  Parametrised GPIO peripheral replacing the fixed 8-bit pin/pout ports at ffff0000 in the rvc top.
//  - Per-bit direction, output and output-enable, with multi-stage input synchronisers.
//  - Edge-detect interrupts with per-bit enable and write-1-to-clear pending bits.
//  - Sits on the rv_core data bus beside rv_sio; the top decodes cs for a 32-byte window.

---
 rtl/rv_gpio.sv | 69 ++++++
 1 files changed

// File: rtl/rv_gpio.sv
// rv_gpio: parametrised GPIO with per-bit direction, synchronised inputs and edge interrupts.
// Optional GPIO_SETCLR_EN adds atomic DOUT set/clear registers at adr 6/7.
module rv_gpio #(
  parameter int W = 8,
  parameter int NSYNC = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [4:0]   adr,
  input  logic         cs,
  input  logic [3:0]   we,
  input  logic         re,
  input  logic [31:0]  dw,
  output logic [31:0]  dr,
  output logic         irq,
  input  logic [W-1:0] pin,
  output logic [W-1:0] pout,
  output logic [W-1:0] poe
);
  logic [NSYNC-1:0][W-1:0] sync;
  logic [W-1:0] dout, dir, ie, ip, edg, prev, din, wm, wd, det, rv;
  logic [31:0] m32;
  logic [2:0] sel;
  logic unused;
  assign unused = ^{adr[1:0], dw};
  assign sel = adr[4:2];
  assign m32 = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
  assign wm = cs ? m32[W-1:0] : '0;
  assign wd = dw[W-1:0] & wm;
  assign din = sync[NSYNC-1];
  assign det = (din & ~prev & ~edg) | (~din & prev & edg);
  assign pout = dout;
  assign poe = dir;
  always_comb
    rv = sel == 3'd0 ? dout :
         sel == 3'd1 ? din  :
         sel == 3'd2 ? dir  :
         sel == 3'd3 ? ie   :
         sel == 3'd4 ? ip   :
         sel == 3'd5 ? edg  : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      prev <= '0;
      dout <= '0;
      dir  <= '0;
      ie   <= '0;
      ip   <= '0;
      edg  <= '0;
      dr   <= '0;
      irq  <= 1'b0;
    end else begin
      sync <= {sync[NSYNC-2:0], pin};
      prev <= din;
      if (sel == 3'd0) dout <= (dout & ~wm) | wd;
`ifdef GPIO_SETCLR_EN
      if (sel == 3'd6) dout <= dout | wd;
      if (sel == 3'd7) dout <= dout & ~wd;
`endif
      if (sel == 3'd2) dir <= (dir & ~wm) | wd;
      if (sel == 3'd3) ie  <= (ie & ~wm) | wd;
      if (sel == 3'd5) edg <= (edg & ~wm) | wd;
      // a fresh edge overrides a simultaneous clear of the same bit
      ip  <= (sel == 3'd4 ? ip & ~wd : ip) | det;
      dr  <= (cs & re) ? 32'(rv) : '0;
      irq <= |(ip & ie);
    end
  end
endmodule
